// File: rtl/mbinit_pkg.sv
// Shared MBINIT definitions: sideband message codes, cfg field layout, PARAM FSM states.
// Pure declarations; no timing.
package mbinit_pkg;

   localparam int CFG_W = 16;

   localparam logic [3:0] MSG_NONE           = 4'd0;
   localparam logic [3:0] MSG_PARAM_CFG_REQ  = 4'd1;
   localparam logic [3:0] MSG_PARAM_CFG_RESP = 4'd2;

   localparam int CFG_RATE_LSB   = 0;
   localparam int CFG_RATE_W     = 4;
   localparam int CFG_SWING_LSB  = 4;
   localparam int CFG_SWING_W    = 5;
   localparam int CFG_CLK_MODE   = 9;
   localparam int CFG_CLK_PHASE  = 10;
   localparam int CFG_MOD_ID_LSB = 11;
   localparam int CFG_MOD_ID_W   = 2;

   typedef enum logic [2:0] {
      R_IDLE      = 3'd0,
      R_SEND_REQ  = 3'd1,
      R_WAIT_RESP = 3'd2,
      R_DONE      = 3'd3,
      R_ERR       = 3'd4
   } req_state_e;

   typedef enum logic [1:0] {
      P_IDLE      = 2'd0,
      P_WAIT_REQ  = 2'd1,
      P_SEND_RESP = 2'd2,
      P_DONE      = 2'd3
   } rsp_state_e;

   function automatic logic [CFG_RATE_W-1:0] cfg_rate(input logic [CFG_W-1:0] cfg);
      return cfg[CFG_RATE_LSB +: CFG_RATE_W];
   endfunction

endpackage

// File: rtl/mbinit_param_exchange_resp_calc.sv
// Builds the PARAM response from our capabilities and the partner's request.
// Purely combinational, zero latency, no flow control.
module param_resp_calc
   import mbinit_pkg::*;
(
   input  logic [CFG_W-1:0] local_cfg_i,
   input  logic [CFG_W-1:0] rx_cfg_i,
   output logic [CFG_W-1:0] resp_cfg_o
);

   logic [CFG_RATE_W-1:0] loc_rate;
   logic [CFG_RATE_W-1:0] rx_rate;
   logic                  unused_cfg_bits;

   assign loc_rate = cfg_rate(local_cfg_i);
   assign rx_rate  = cfg_rate(rx_cfg_i);

   // Rate is the common minimum; electrical fields follow the requester; module ID stays ours.
   always_comb begin
      resp_cfg_o = '0;
      resp_cfg_o[CFG_RATE_LSB +: CFG_RATE_W]     = (loc_rate < rx_rate) ? loc_rate : rx_rate;
      resp_cfg_o[CFG_SWING_LSB +: CFG_SWING_W]   = rx_cfg_i[CFG_SWING_LSB +: CFG_SWING_W];
      resp_cfg_o[CFG_CLK_MODE]                   = rx_cfg_i[CFG_CLK_MODE];
      resp_cfg_o[CFG_CLK_PHASE]                  = rx_cfg_i[CFG_CLK_PHASE];
      resp_cfg_o[CFG_MOD_ID_LSB +: CFG_MOD_ID_W] = local_cfg_i[CFG_MOD_ID_LSB +: CFG_MOD_ID_W];
   end

   assign unused_cfg_bits = ^{local_cfg_i[CFG_CLK_PHASE:CFG_SWING_LSB],
                              local_cfg_i[CFG_W-1:CFG_MOD_ID_LSB+CFG_MOD_ID_W],
                              rx_cfg_i[CFG_W-1:CFG_MOD_ID_LSB]};

endmodule

// File: rtl/mbinit_param_exchange.sv
// MBINIT PARAM exchange: requester and responder FSMs sharing one sideband TX port.
// TX valid is combinational from state; responder wins TX contention, requester waits.
module mbinit_param_exchange
   import mbinit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             i_MBINIT_start,
   input  logic [CFG_W-1:0] i_local_cfg,
   input  logic [3:0]       i_RX_SbMessage,
   input  logic [CFG_W-1:0] i_rx_cfg,
   input  logic             i_msg_valid,
   input  logic             i_falling_edge_busy,
   output logic [3:0]       o_TX_SbMessage,
   output logic [CFG_W-1:0] o_tx_cfg,
   output logic             o_ValidOutDatat_PARAM,
   output logic [CFG_W-1:0] o_negotiated_cfg,
   output logic             o_MBINIT_PARAM_end,
   output logic             o_param_error
);

   localparam int               CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   req_state_e       req_state_q, req_state_d;
   rsp_state_e       rsp_state_q, rsp_state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CFG_W-1:0] local_q, local_d;
   logic [CFG_W-1:0] resp_q, resp_d;
   logic [CFG_W-1:0] neg_q, neg_d;
   logic             end_q, end_d;

   logic [CFG_W-1:0] calc_resp;
   logic             rx_req, rx_resp, resp_ok;
   logic             req_vld, rsp_vld, req_gnt;

   param_resp_calc u_resp_calc (
      .local_cfg_i (local_q),
      .rx_cfg_i    (i_rx_cfg),
      .resp_cfg_o  (calc_resp)
   );

   assign rx_req  = i_msg_valid && (i_RX_SbMessage == MSG_PARAM_CFG_REQ);
   assign rx_resp = i_msg_valid && (i_RX_SbMessage == MSG_PARAM_CFG_RESP);
   assign resp_ok = (cfg_rate(i_rx_cfg) != '0) && (cfg_rate(i_rx_cfg) <= cfg_rate(local_q));

   assign req_vld = (req_state_q == R_SEND_REQ);
   assign rsp_vld = (rsp_state_q == P_SEND_RESP);
   assign req_gnt = req_vld && !rsp_vld;

   always_comb begin
      req_state_d = req_state_q;
      cnt_d       = cnt_q;
      local_d     = local_q;
      neg_d       = neg_q;
      case (req_state_q)
         R_IDLE: begin
            if (i_MBINIT_start) begin
               req_state_d = R_SEND_REQ;
               local_d     = i_local_cfg;
            end
         end
         R_SEND_REQ: begin
            if (req_gnt && i_falling_edge_busy) begin
               req_state_d = R_WAIT_RESP;
               cnt_d       = '0;
            end
         end
         R_WAIT_RESP: begin
            // A RESP arriving on the last allowed cycle still wins over the timeout.
            if (rx_resp) begin
               neg_d       = i_rx_cfg;
               req_state_d = resp_ok ? R_DONE : R_ERR;
            end else if (cnt_q == TO_LAST) begin
               req_state_d = R_ERR;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      rsp_state_d = rsp_state_q;
      resp_d      = resp_q;
      case (rsp_state_q)
         P_IDLE: begin
            if (i_MBINIT_start) rsp_state_d = P_WAIT_REQ;
         end
         P_WAIT_REQ: begin
            if (rx_req) begin
               resp_d      = calc_resp;
               rsp_state_d = P_SEND_RESP;
            end
         end
         P_SEND_RESP: begin
            if (i_falling_edge_busy) rsp_state_d = P_DONE;
         end
         default: ;
      endcase
   end

   assign end_d = end_q || ((req_state_q == R_DONE) && (rsp_state_q == P_DONE));

   always_ff @(posedge CLK) begin
      if (rst) begin
         req_state_q <= R_IDLE;
         rsp_state_q <= P_IDLE;
         cnt_q       <= '0;
         local_q     <= '0;
         resp_q      <= '0;
         neg_q       <= '0;
         end_q       <= 1'b0;
      end else begin
         req_state_q <= req_state_d;
         rsp_state_q <= rsp_state_d;
         cnt_q       <= cnt_d;
         local_q     <= local_d;
         resp_q      <= resp_d;
         neg_q       <= neg_d;
         end_q       <= end_d;
      end
   end

   always_comb begin
      o_ValidOutDatat_PARAM = req_vld || rsp_vld;
      o_TX_SbMessage        = MSG_NONE;
      o_tx_cfg              = '0;
      if (rsp_vld) begin
         o_TX_SbMessage = MSG_PARAM_CFG_RESP;
         o_tx_cfg       = resp_q;
      end else if (req_gnt) begin
         o_TX_SbMessage = MSG_PARAM_CFG_REQ;
         o_tx_cfg       = local_q;
      end
   end

   assign o_negotiated_cfg   = neg_q;
   assign o_MBINIT_PARAM_end = end_q;
   assign o_param_error      = (req_state_q == R_ERR);

endmodule
